// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser: drains RX FIFO bytes into a 4-byte command packet, validates
// length/checksum/opcode, executes a register write or read, and pushes a
// 2-byte ACK/NAK response into the TX FIFO. All outputs are registered.
module uart_cmd_parser #(
  parameter logic [7:0] CMD_WRITE = 8'h57,
  parameter logic [7:0] CMD_READ  = 8'h52,
  parameter logic [7:0] ACK_BYTE  = 8'h06,
  parameter logic [7:0] NAK_BYTE  = 8'h15
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx_fifo_empty,
  input  logic [7:0] rx_fifo_data_out,
  output logic       rx_fifo_read_en,
  input  logic       packet_received,
  input  logic       tx_fifo_full,
  output logic [7:0] tx_fifo_data_in,
  output logic       tx_fifo_write_en,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_wr_en,
  output logic       reg_rd_en,
  input  logic [7:0] reg_rdata,
  output logic       busy,
  output logic [7:0] pkt_ok_count,
  output logic [7:0] pkt_err_count
);

  typedef enum logic [2:0] {
    S_COLLECT = 3'd0,
    S_EVAL    = 3'd1,
    S_WRITE   = 3'd2,
    S_READ    = 3'd3,
    S_RDLAT   = 3'd4,
    S_SEND0   = 3'd5,
    S_SEND1   = 3'd6
  } state_t;

  state_t     state_r, next_state_s;
  logic [2:0] idx_r;          // 0..4 = bytes captured, 5 = overflow
  logic       pending_r;      // end-of-packet seen, evaluation owed
  logic       capture_r;      // RX data for last pop is valid this cycle
  logic [7:0] buf_r [4];
  logic [7:0] rsp0_r, rsp1_r;
  logic [7:0] err_code_s;
  logic       tx_go_s;        // TX may accept a byte now
  logic       send_done_s;
  logic       rx_read_en_s, tx_write_en_s, reg_wr_en_s, reg_rd_en_s, busy_s;
  logic [7:0] tx_data_s, reg_addr_s, reg_wdata_s;

  function automatic logic [7:0] pkt_checksum(input logic [7:0] b0,
                                              input logic [7:0] b1,
                                              input logic [7:0] b2);
    return b0 + b1 + b2;
  endfunction

  // Packet validation: error code in priority order, 0 means executable
  always_comb begin
    err_code_s = 8'h00;
    if (idx_r != 3'd4) begin
      err_code_s = 8'h01;
    end else if (pkt_checksum(buf_r[0], buf_r[1], buf_r[2]) != buf_r[3]) begin
      err_code_s = 8'h02;
    end else if ((buf_r[0] != CMD_WRITE) && (buf_r[0] != CMD_READ)) begin
      err_code_s = 8'h03;
    end else begin
      err_code_s = 8'h00;
    end
  end

  // A push waits one idle cycle after the previous push so the full flag
  // already reflects that byte before the next decision.
  assign tx_go_s = !tx_fifo_full && !tx_fifo_write_en;

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r <= S_COLLECT;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      S_COLLECT: begin
        if (pending_r && rx_fifo_empty && !rx_fifo_read_en) next_state_s = S_EVAL;
        else                                                next_state_s = S_COLLECT;
      end
      S_EVAL: begin
        if (err_code_s != 8'h00)        next_state_s = S_SEND0;
        else if (buf_r[0] == CMD_WRITE) next_state_s = S_WRITE;
        else                            next_state_s = S_READ;
      end
      S_WRITE: next_state_s = S_SEND0;
      S_READ:  next_state_s = S_RDLAT;
      S_RDLAT: next_state_s = S_SEND0;
      S_SEND0: begin
        if (tx_go_s) next_state_s = S_SEND1;
        else         next_state_s = S_SEND0;
      end
      S_SEND1: begin
        if (tx_go_s) next_state_s = S_COLLECT;
        else         next_state_s = S_SEND1;
      end
      default: next_state_s = S_COLLECT;
    endcase
  end

  // Output logic: next values of the registered outputs
  always_comb begin
    rx_read_en_s  = 1'b0;
    reg_wr_en_s   = 1'b0;
    reg_rd_en_s   = 1'b0;
    tx_write_en_s = 1'b0;
    reg_addr_s    = reg_addr;
    reg_wdata_s   = reg_wdata;
    tx_data_s     = tx_fifo_data_in;
    send_done_s   = 1'b0;

    if ((state_r == S_COLLECT) && (next_state_s == S_COLLECT) &&
        !rx_fifo_empty && !rx_fifo_read_en) begin
      rx_read_en_s = 1'b1;
    end else begin
      rx_read_en_s = 1'b0;
    end

    if (next_state_s == S_WRITE) begin
      reg_wr_en_s = 1'b1;
      reg_addr_s  = buf_r[1];
      reg_wdata_s = buf_r[2];
    end else if (next_state_s == S_READ) begin
      reg_rd_en_s = 1'b1;
      reg_addr_s  = buf_r[1];
    end else begin
      reg_wr_en_s = 1'b0;
      reg_rd_en_s = 1'b0;
    end

    if ((state_r == S_SEND0) && tx_go_s) begin
      tx_write_en_s = 1'b1;
      tx_data_s     = rsp0_r;
    end else if ((state_r == S_SEND1) && tx_go_s) begin
      tx_write_en_s = 1'b1;
      tx_data_s     = rsp1_r;
      send_done_s   = 1'b1;
    end else begin
      tx_write_en_s = 1'b0;
    end

    busy_s = (next_state_s != S_COLLECT);
  end

  // Packet datapath: byte capture, pending flag, response bytes
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      idx_r     <= 3'd0;
      pending_r <= 1'b0;
      capture_r <= 1'b0;
      rsp0_r    <= 8'h00;
      rsp1_r    <= 8'h00;
      for (int i = 0; i < 4; i++) buf_r[i] <= 8'h00;
    end else begin
      capture_r <= rx_fifo_read_en;

      if (packet_received) begin
        pending_r <= 1'b1;
      end else if ((state_r == S_COLLECT) && (next_state_s == S_EVAL)) begin
        pending_r <= 1'b0;
      end else begin
        pending_r <= pending_r;
      end

      if (capture_r) begin
        if (idx_r < 3'd4) buf_r[idx_r[1:0]] <= rx_fifo_data_out;
        if (idx_r < 3'd5) idx_r <= idx_r + 3'd1;
      end else if (send_done_s) begin
        idx_r <= 3'd0;
      end else begin
        idx_r <= idx_r;
      end

      if (state_r == S_EVAL) begin
        rsp0_r <= (err_code_s != 8'h00) ? NAK_BYTE : ACK_BYTE;
        rsp1_r <= (err_code_s != 8'h00) ? err_code_s : buf_r[1];
      end else if (state_r == S_RDLAT) begin
        rsp1_r <= reg_rdata;
      end else begin
        rsp1_r <= rsp1_r;
      end
    end
  end

  // Registered outputs and saturating packet counters
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_fifo_read_en  <= 1'b0;
      tx_fifo_write_en <= 1'b0;
      tx_fifo_data_in  <= 8'h00;
      reg_addr         <= 8'h00;
      reg_wdata        <= 8'h00;
      reg_wr_en        <= 1'b0;
      reg_rd_en        <= 1'b0;
      busy             <= 1'b0;
      pkt_ok_count     <= 8'h00;
      pkt_err_count    <= 8'h00;
    end else begin
      rx_fifo_read_en  <= rx_read_en_s;
      tx_fifo_write_en <= tx_write_en_s;
      tx_fifo_data_in  <= tx_data_s;
      reg_addr         <= reg_addr_s;
      reg_wdata        <= reg_wdata_s;
      reg_wr_en        <= reg_wr_en_s;
      reg_rd_en        <= reg_rd_en_s;
      busy             <= busy_s;
      if (send_done_s && (rsp0_r == ACK_BYTE)) begin
        if (pkt_ok_count != 8'hFF) pkt_ok_count <= pkt_ok_count + 8'd1;
      end else if (send_done_s) begin
        if (pkt_err_count != 8'hFF) pkt_err_count <= pkt_err_count + 8'd1;
      end else begin
        pkt_ok_count <= pkt_ok_count;
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Testbench for uart_cmd_parser: models the RX/TX FIFOs and a register slave,
// and checks every response against a packet-level reference model.
module tb_uart_cmd_parser;

  logic       clock = 1'b0;
  logic       reset;
  logic       rx_fifo_empty = 1'b1;
  logic [7:0] rx_fifo_data_out = 8'h00;
  logic       rx_fifo_read_en;
  logic       packet_received;
  logic       tx_fifo_full;
  logic [7:0] tx_fifo_data_in;
  logic       tx_fifo_write_en;
  logic [7:0] reg_addr, reg_wdata;
  logic       reg_wr_en, reg_rd_en;
  logic [7:0] reg_rdata = 8'h00;
  logic       busy;
  logic [7:0] pkt_ok_count, pkt_err_count;

  logic       push_en;
  logic [7:0] push_byte;
  logic [7:0] rx_q [$];
  logic [7:0] tx_got [$];
  logic [15:0] wr_q [$];
  logic [7:0] rd_q [$];
  logic [7:0] slave_mem [256];
  logic [7:0] model_mem [256];
  bit         mem_init = 1'b0;
  int         full_viol = 0;
  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] pkt [8];
  int         pkt_len;
  int         model_ok, model_err;

  typedef struct {
    logic [7:0] r0, r1;
    bit         w, r;
    logic [7:0] addr, data, ok, err;
  } exp_t;
  exp_t exp_q [$];

  uart_cmd_parser dut (
    .clock(clock), .reset(reset),
    .rx_fifo_empty(rx_fifo_empty), .rx_fifo_data_out(rx_fifo_data_out),
    .rx_fifo_read_en(rx_fifo_read_en), .packet_received(packet_received),
    .tx_fifo_full(tx_fifo_full), .tx_fifo_data_in(tx_fifo_data_in),
    .tx_fifo_write_en(tx_fifo_write_en), .reg_addr(reg_addr),
    .reg_wdata(reg_wdata), .reg_wr_en(reg_wr_en), .reg_rd_en(reg_rd_en),
    .reg_rdata(reg_rdata), .busy(busy), .pkt_ok_count(pkt_ok_count),
    .pkt_err_count(pkt_err_count)
  );

  always #5 clock = ~clock;

  // RX FIFO: pop data appears the cycle after the read enable
  always @(posedge clock) begin
    if (rx_fifo_read_en && (rx_q.size() > 0)) rx_fifo_data_out <= rx_q.pop_front();
    if (push_en) rx_q.push_back(push_byte);
    rx_fifo_empty <= (rx_q.size() == 0);
  end

  // TX FIFO sink: records pushed bytes and any push while full
  always @(posedge clock) begin
    if (tx_fifo_write_en) begin
      if (tx_fifo_full) full_viol <= full_viol + 1;
      tx_got.push_back(tx_fifo_data_in);
    end
  end

  // Register slave with one-cycle read latency
  always @(posedge clock) begin
    if (!mem_init) begin
      for (int i = 0; i < 256; i++) slave_mem[i] <= 8'(i) ^ 8'h1C;
      mem_init <= 1'b1;
    end else begin
      if (reg_wr_en) begin
        slave_mem[reg_addr] <= reg_wdata;
        wr_q.push_back({reg_addr, reg_wdata});
      end
      if (reg_rd_en) begin
        reg_rdata <= slave_mem[reg_addr];
        rd_q.push_back(reg_addr);
      end
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: expected response of the packet held in pkt/pkt_len
  task automatic model_pkt();
    exp_t e;
    logic [7:0] s;
    e.w = 1'b0; e.r = 1'b0; e.addr = 8'h00; e.data = 8'h00;
    s = pkt[0] + pkt[1] + pkt[2];
    if (pkt_len != 4) begin
      e.r0 = 8'h15; e.r1 = 8'h01;
    end else if (s != pkt[3]) begin
      e.r0 = 8'h15; e.r1 = 8'h02;
    end else if (pkt[0] == 8'h57) begin
      e.w = 1'b1; e.addr = pkt[1]; e.data = pkt[2];
      model_mem[pkt[1]] = pkt[2];
      e.r0 = 8'h06; e.r1 = pkt[1];
    end else if (pkt[0] == 8'h52) begin
      e.r = 1'b1; e.addr = pkt[1];
      e.r0 = 8'h06; e.r1 = model_mem[pkt[1]];
    end else begin
      e.r0 = 8'h15; e.r1 = 8'h03;
    end
    if (e.r0 == 8'h06) model_ok = (model_ok < 255) ? model_ok + 1 : 255;
    else               model_err = (model_err < 255) ? model_err + 1 : 255;
    e.ok = 8'(model_ok); e.err = 8'(model_err);
    exp_q.push_back(e);
  endtask

  task automatic set4(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
    pkt[0] = a; pkt[1] = b; pkt[2] = c; pkt[3] = d; pkt_len = 4;
  endtask

  // Push pkt bytes one per cycle, then pulse end-of-packet
  task automatic send_pkt();
    for (int i = 0; i < pkt_len; i++) begin
      push_en = 1'b1; push_byte = pkt[i];
      @(negedge clock);
    end
    push_en = 1'b0;
    packet_received = 1'b1;
    @(negedge clock);
    packet_received = 1'b0;
    model_pkt();
  endtask

  // Wait for the oldest expected response and check it
  task automatic check_done(input string tag);
    exp_t e;
    int cyc;
    logic [15:0] w;
    logic [7:0] ra;
    e = exp_q.pop_front();
    cyc = 0;
    while ((tx_got.size() < 2) && (cyc < 600)) begin
      @(negedge clock);
      cyc++;
    end
    check_val($sformatf("%s_rsp_arrived", tag), 32'(tx_got.size() >= 2), 32'd1);
    if (tx_got.size() >= 2) begin
      check_val($sformatf("%s_tx0", tag), 32'(tx_got.pop_front()), 32'(e.r0));
      check_val($sformatf("%s_tx1", tag), 32'(tx_got.pop_front()), 32'(e.r1));
    end
    check_val($sformatf("%s_wr_strobes", tag), 32'(wr_q.size()), 32'(e.w));
    check_val($sformatf("%s_rd_strobes", tag), 32'(rd_q.size()), 32'(e.r));
    if (e.w && (wr_q.size() > 0)) begin
      w = wr_q.pop_front();
      check_val($sformatf("%s_wr_addr_data", tag), 32'(w), 32'({e.addr, e.data}));
    end
    if (e.r && (rd_q.size() > 0)) begin
      ra = rd_q.pop_front();
      check_val($sformatf("%s_rd_addr", tag), 32'(ra), 32'(e.addr));
    end
    check_val($sformatf("%s_ok_cnt", tag), 32'(pkt_ok_count), 32'(e.ok));
    check_val($sformatf("%s_err_cnt", tag), 32'(pkt_err_count), 32'(e.err));
    wr_q.delete();
    rd_q.delete();
    repeat (2) @(negedge clock);
  endtask

  initial begin
    int cyc;
    int kind;
    reset = 1'b0; packet_received = 1'b0; tx_fifo_full = 1'b0;
    push_en = 1'b0; push_byte = 8'h00;
    model_ok = 0; model_err = 0;
    for (int i = 0; i < 256; i++) model_mem[i] = 8'(i) ^ 8'h1C;
    repeat (3) @(negedge clock);

    check_val("rst_read_en", 32'(rx_fifo_read_en), 32'd0);
    check_val("rst_write_en", 32'(tx_fifo_write_en), 32'd0);
    check_val("rst_wr_en", 32'(reg_wr_en), 32'd0);
    check_val("rst_rd_en", 32'(reg_rd_en), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_counts", 32'({pkt_ok_count, pkt_err_count}), 32'd0);
    check_val("rst_data", 32'({tx_fifo_data_in, reg_addr, reg_wdata}), 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clock);

    // Write then read, then each error class
    set4(8'h57, 8'h10, 8'hA5, 8'h0C); send_pkt(); check_done("t1_write");
    set4(8'h52, 8'h20, 8'h00, 8'h72); send_pkt(); check_done("t2_read");
    set4(8'h57, 8'h10, 8'hA5, 8'h00); send_pkt(); check_done("t3_cksum");
    set4(8'h41, 8'h00, 8'h00, 8'h41); send_pkt(); check_done("t3_opcode");
    pkt[0] = 8'h57; pkt[1] = 8'h10; pkt_len = 2; send_pkt(); check_done("t3_short");
    set4(8'h57, 8'h10, 8'hA5, 8'h0C); pkt[4] = 8'h00; pkt_len = 5;
    send_pkt(); check_done("t3_long");
    pkt_len = 0; send_pkt(); check_done("t3_spurious");

    // TX back-pressure
    tx_fifo_full = 1'b1;
    set4(8'h57, 8'h10, 8'hA5, 8'h0C); send_pkt();
    repeat (40) @(negedge clock);
    check_val("t4_no_push_while_full", 32'(tx_got.size()), 32'd0);
    check_val("t4_busy_while_full", 32'(busy), 32'd1);
    tx_fifo_full = 1'b0;
    check_done("t4_full");

    // Second packet arrives while the first is still responding
    tx_fifo_full = 1'b1;
    set4(8'h57, 8'h44, 8'h99, 8'h57 + 8'h44 + 8'h99); send_pkt();
    cyc = 0;
    while (!busy && (cyc < 100)) begin @(negedge clock); cyc++; end
    check_val("t5_busy_seen", 32'(busy), 32'd1);
    set4(8'h52, 8'h44, 8'h00, 8'h52 + 8'h44); send_pkt();
    tx_fifo_full = 1'b0;
    check_done("t5_first");
    check_done("t5_second");

    // Reset between the two response bytes
    set4(8'h57, 8'h33, 8'h44, 8'h57 + 8'h33 + 8'h44); send_pkt();
    cyc = 0;
    while ((tx_got.size() < 1) && (cyc < 600)) begin @(negedge clock); cyc++; end
    check_val("t6_first_byte_seen", 32'(tx_got.size()), 32'd1);
    reset = 1'b0;
    #1;
    check_val("t6_rst_write_en", 32'(tx_fifo_write_en), 32'd0);
    check_val("t6_rst_busy", 32'(busy), 32'd0);
    check_val("t6_rst_counts", 32'({pkt_ok_count, pkt_err_count}), 32'd0);
    repeat (6) @(negedge clock);
    check_val("t6_only_one_byte", 32'(tx_got.size()), 32'd1);
    if (tx_got.size() > 0) check_val("t6_byte0", 32'(tx_got[0]), 32'h06);
    tx_got.delete(); exp_q.delete(); wr_q.delete(); rd_q.delete();
    model_ok = 0; model_err = 0;
    reset = 1'b1;
    repeat (2) @(negedge clock);
    set4(8'h52, 8'h33, 8'h00, 8'h52 + 8'h33); send_pkt(); check_done("t6_after");

    // Randomized packets
    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 5);
      case (kind)
        0: set4(8'h57, 8'($urandom), 8'($urandom), 8'h00);
        1: set4(8'h52, 8'($urandom_range(0, 63)), 8'($urandom), 8'h00);
        2: set4(($urandom_range(0, 1) == 0) ? 8'h57 : 8'h52, 8'($urandom), 8'($urandom), 8'h00);
        3: begin
          set4(8'($urandom), 8'($urandom), 8'($urandom), 8'h00);
          while ((pkt[0] == 8'h57) || (pkt[0] == 8'h52)) pkt[0] = 8'($urandom);
        end
        4: begin
          pkt_len = $urandom_range(0, 3);
          for (int i = 0; i < 8; i++) pkt[i] = 8'($urandom);
        end
        default: begin
          pkt_len = $urandom_range(5, 6);
          for (int i = 0; i < 8; i++) pkt[i] = 8'($urandom);
        end
      endcase
      if (kind <= 3) pkt[3] = pkt[0] + pkt[1] + pkt[2];
      if (kind == 2) pkt[3] = pkt[3] ^ 8'($urandom_range(1, 255));
      if ($urandom_range(0, 3) == 0) begin
        tx_fifo_full = 1'b1;
        send_pkt();
        repeat ($urandom_range(1, 15)) @(negedge clock);
        tx_fifo_full = 1'b0;
      end else begin
        send_pkt();
      end
      check_done($sformatf("rnd%0d", n));
    end

    repeat (10) @(negedge clock);
    check_val("push_while_full", 32'(full_viol), 32'd0);
    check_val("extra_tx_bytes", 32'(tx_got.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
